// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: MSB-first serial-to-parallel receiver with COMMA byte alignment; optional COMMA counter via SERIAL_PARALELO_COMMA_CNT_EN
module serial_paralelo_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter logic [7:0]  IDLE       = 8'h7C,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
    output logic [7:0] comma_seen,
`endif
    output logic       byte_strobe
);
    typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;
    localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];
    state_t      state_q, state_d;
    logic [6:0]  sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  comma_cnt_q, comma_cnt_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        strobe_q, strobe_d;
    logic [7:0]  comma_seen_q, comma_seen_d;
    logic [7:0]  window;
    logic        boundary;
    logic        is_comma;
    assign window   = {sr_q, data_in};
    assign boundary = bit_cnt_q == 3'd7;
    assign is_comma = window == COMMA;
    // next-state: bitwise comma hunt, aligned lock counting, then byte delivery
    always_comb begin
        state_d      = state_q;
        sr_d         = window[6:0];
        bit_cnt_d    = bit_cnt_q + 3'd1;
        comma_cnt_d  = comma_cnt_q;
        data_out_d   = data_out_q;
        valid_d      = valid_q;
        active_d     = active_q;
        strobe_d     = 1'b0;
        comma_seen_d = comma_seen_q;
        case (state_q)
            SEARCH: begin
                if (is_comma) begin
                    bit_cnt_d   = 3'd0;
                    comma_cnt_d = 4'd1;
                    state_d     = (LOCK_N == 4'd1) ? ACTIVE : LOCKING;
                    active_d    = LOCK_N == 4'd1;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    comma_cnt_d = is_comma ? comma_cnt_q + 4'd1 : 4'd0;
                    state_d     = !is_comma ? SEARCH : (comma_cnt_d == LOCK_N) ? ACTIVE : LOCKING;
                    active_d    = is_comma && comma_cnt_d == LOCK_N;
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    data_out_d   = window;
                    strobe_d     = 1'b1;
                    valid_d      = !is_comma && window != IDLE;
                    comma_seen_d = (is_comma && comma_seen_q != 8'hFF) ? comma_seen_q + 8'd1 : comma_seen_q;
                end
            end
            default: state_d = SEARCH;
        endcase
    end
    // state and output registers; reset clears everything without waiting for a clock
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= SEARCH;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            comma_cnt_q  <= '0;
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            active_q     <= 1'b0;
            strobe_q     <= 1'b0;
            comma_seen_q <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            comma_cnt_q  <= comma_cnt_d;
            data_out_q   <= data_out_d;
            valid_q      <= valid_d;
            active_q     <= active_d;
            strobe_q     <= strobe_d;
            comma_seen_q <= comma_seen_d;
        end
    end
    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign byte_strobe = strobe_q;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
    assign comma_seen  = comma_seen_q;
`else
    logic unused_cs;
    assign unused_cs = ^comma_seen_q;
`endif
endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: scoreboard bench for the serial receiver; expected bytes queued by stimulus, checked by a strobe monitor
module tb_serial_paralelo_rx;
    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, active, byte_strobe;
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
    logic [7:0] comma_seen;
`endif
    int tests = 0;
    int fails = 0;
    logic [8:0] sb[$];

    serial_paralelo_rx dut (
        .clk_32f(clk_32f),
        .reset_L(reset_L),
        .data_in(data_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .active(active),
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
        .comma_seen(comma_seen),
`endif
        .byte_strobe(byte_strobe)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_exp(input logic [7:0] b, input logic v);
        sb.push_back({v, b});
        send_byte(b);
    endtask

    // monitor: every strobe must match the oldest expected byte
    always @(negedge clk_32f) begin
        if (reset_L && byte_strobe) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_strobe: got data %0h valid %0b expected no strobe", data_out, valid_out);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("strobe_data", {24'd0, data_out}, {24'd0, e[7:0]});
                chk("strobe_valid", {31'd0, valid_out}, {31'd0, e[8]});
            end
        end
    end

    initial begin
        #400000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        // reset held for 3 cycles with random serial data
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        #1;
        chk("rst_data", {24'd0, data_out}, 0);
        chk("rst_valid", {31'd0, valid_out}, 0);
        chk("rst_active", {31'd0, active}, 0);
        chk("rst_strobe", {31'd0, byte_strobe}, 0);
        @(negedge clk_32f);
        #2 reset_L = 1'b1;
        // lock after 3 random bits and four COMMAs
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        chk("lock_pre3", {31'd0, active}, 0);
        send_byte(8'hBC);
        chk("lock_pre4", {31'd0, active}, 0);
        @(posedge clk_32f);
        #1 chk("lock_rise", {31'd0, active}, 1);
        chk("lock_valid", {31'd0, valid_out}, 0);
        // payload / IDLE / COMMA classification
        send_exp(8'hA5, 1'b1);
        send_exp(8'h7C, 1'b0);
        send_exp(8'h3C, 1'b1);
        send_exp(8'hBC, 1'b0);
        // COMMA straddling a byte boundary must not realign
        send_exp(8'h0B, 1'b1);
        send_exp(8'hC0, 1'b1);
        repeat (3) @(posedge clk_32f);
        chk("hold_active", {31'd0, active}, 1);
        // asynchronous reset between edges while active
        @(negedge clk_32f);
        #2 reset_L = 1'b0;
        #1;
        chk("arst_data", {24'd0, data_out}, 0);
        chk("arst_valid", {31'd0, valid_out}, 0);
        chk("arst_active", {31'd0, active}, 0);
        chk("arst_strobe", {31'd0, byte_strobe}, 0);
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
        chk("arst_cs", {24'd0, comma_seen}, 0);
`endif
        @(negedge clk_32f);
        #2 reset_L = 1'b1;
        // broken training sequence
        send_byte(8'hBC);
        send_byte(8'hBC);
        send_byte(8'h55);
        chk("brk_after55", {31'd0, active}, 0);
        send_byte(8'hBC);
        send_byte(8'hBC);
        chk("brk_after2", {31'd0, active}, 0);
        send_byte(8'hBC);
        chk("brk_after3", {31'd0, active}, 0);
        send_byte(8'hBC);
        @(posedge clk_32f);
        #1 chk("brk_lock", {31'd0, active}, 1);
        send_exp(8'h12, 1'b1);
`ifdef SERIAL_PARALELO_COMMA_CNT_EN
        @(posedge clk_32f);
        #1 chk("cs_start", {24'd0, comma_seen}, 0);
        send_exp(8'hBC, 1'b0);
        send_exp(8'hBC, 1'b0);
        send_exp(8'h7C, 1'b0);
        send_exp(8'h5A, 1'b1);
        send_exp(8'hBC, 1'b0);
        @(posedge clk_32f);
        #1 chk("cs_three", {24'd0, comma_seen}, 3);
        for (int i = 0; i < 297; i++) send_exp(8'hBC, 1'b0);
        @(posedge clk_32f);
        #1 chk("cs_sat", {24'd0, comma_seen}, 8'hFF);
        send_exp(8'h7C, 1'b0);
        @(posedge clk_32f);
        #1 chk("cs_sat_hold", {24'd0, comma_seen}, 8'hFF);
        reset_L = 1'b0;
        #1 chk("cs_reset", {24'd0, comma_seen}, 0);
        @(negedge clk_32f);
        #2 reset_L = 1'b1;
`endif
        repeat (3) @(posedge clk_32f);
        #1 chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
